// File: rtl/l2_req_arbiter.sv
// Shares one L2 request port between L1 instr and data caches; one block transaction in flight, request registered (grant visible next cycle).
// Backpressure: a requester holds Valid until its steered Ready; nothing new is granted until L2 answers the granted Src.
module l2_req_arbiter #(
    parameter int unsigned FIXED_PRIO = 0,
    parameter bit          SRC_INSTR  = 1'b0,
    parameter bit          SRC_DATA   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [161:0] InstrReq,
    input  logic [161:0] DataReq,
    input  logic [129:0] L2Resp,
    output logic [162:0] L2Req,
    output logic [128:0] InstrResp,
    output logic [128:0] DataResp,
    output logic         Busy,
    output logic         DstErr
);

    typedef struct packed {
        logic         Valid;
        logic         Wen;
        logic [31:0]  Addr;
        logic [127:0] WriteD;
    } cache_to_mem_t;

    typedef struct packed {
        logic         Valid;
        logic         Wen;
        logic         Src;
        logic [31:0]  Addr;
        logic [127:0] WriteD;
    } l1_to_l2_t;

    typedef struct packed {
        logic         Ready;
        logic         Dst;
        logic [127:0] ReadD;
    } l2_to_l1_t;

    typedef struct packed {
        logic         Ready;
        logic [127:0] ReadD;
    } mem_to_cache_t;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    cache_to_mem_t ireq, dreq;
    l2_to_l1_t     resp;
    l1_to_l2_t     req_q;
    mem_to_cache_t iresp, dresp;
    state_t        state, state_nxt;
    logic          last_grant;
    logic          dst_err_q;
    logic          grant_data, grant_instr, resp_match;

    assign ireq  = InstrReq;
    assign dreq  = DataReq;
    assign resp  = L2Resp;
    assign L2Req = req_q;

    // Data wins a tie under fixed priority, or under round-robin when instr was granted last.
    assign grant_data  = dreq.Valid && (!ireq.Valid || FIXED_PRIO != 0 || last_grant == SRC_INSTR);
    assign grant_instr = ireq.Valid && !grant_data;
    assign resp_match  = resp.Ready && (resp.Dst == req_q.Src);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_data)       state_nxt = BUSY_D;
                else if (grant_instr) state_nxt = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (resp_match) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Busy        = (state != IDLE);
        DstErr      = dst_err_q;
        iresp.Ready = resp.Ready && (state == BUSY_I) && (resp.Dst == SRC_INSTR);
        iresp.ReadD = resp.ReadD;
        dresp.Ready = resp.Ready && (state == BUSY_D) && (resp.Dst == SRC_DATA);
        dresp.ReadD = resp.ReadD;
        InstrResp   = iresp;
        DataResp    = dresp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= '0;
            last_grant <= SRC_INSTR;
            dst_err_q  <= 1'b0;
        end else begin
            if (state == IDLE && (grant_data || grant_instr)) begin
                req_q.Valid  <= 1'b1;
                req_q.Wen    <= grant_data ? dreq.Wen    : ireq.Wen;
                req_q.Src    <= grant_data ? SRC_DATA    : SRC_INSTR;
                req_q.Addr   <= grant_data ? dreq.Addr   : ireq.Addr;
                req_q.WriteD <= grant_data ? dreq.WriteD : ireq.WriteD;
                last_grant   <= grant_data ? SRC_DATA    : SRC_INSTR;
            end else if (state != IDLE && resp_match) begin
                req_q.Valid <= 1'b0;
            end
            if (state != IDLE && resp.Ready && !resp_match)
                dst_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Bench for l2_req_arbiter: round-robin instance driven by hand sequences and a vector table, fixed-priority instance by a tie loop.
module tb_l2_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [161:0] InstrReq, DataReq, f_instr_req, f_data_req;
    logic [129:0] L2Resp, f_l2_resp;
    logic [162:0] L2Req, f_l2_req;
    logic [128:0] InstrResp, DataResp, f_instr_resp, f_data_resp;
    logic         Busy, DstErr, f_busy, f_dst_err;

    l2_req_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst), .InstrReq(InstrReq), .DataReq(DataReq), .L2Resp(L2Resp),
        .L2Req(L2Req), .InstrResp(InstrResp), .DataResp(DataResp), .Busy(Busy), .DstErr(DstErr)
    );

    l2_req_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst), .InstrReq(f_instr_req), .DataReq(f_data_req), .L2Resp(f_l2_resp),
        .L2Req(f_l2_req), .InstrResp(f_instr_resp), .DataResp(f_data_resp), .Busy(f_busy), .DstErr(f_dst_err)
    );

    typedef struct {
        logic        iv;
        logic        dv;
        logic        wen;
        logic [31:0] ia;
        logic [31:0] da;
        logic        src;
    } vec_t;

    vec_t         vecs[6];
    logic [162:0] sb[$];
    int           total = 0;
    int           bad   = 0;

    localparam logic [127:0] RD_A = 128'hDEADBEEF_00000000_11111111_DEADBEEF;
    localparam logic [127:0] WB_D = 128'h0123456789ABCDEF_0123456789ABCDEF;

    function automatic logic [161:0] mk(input logic v, input logic w, input logic [31:0] a, input logic [127:0] d);
        return {v, w, a, d};
    endfunction

    task automatic chk(input string nm, input logic [162:0] act, input logic [162:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        InstrReq = '0; DataReq = '0; L2Resp = '0;
        f_instr_req = '0; f_data_req = '0; f_l2_resp = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // One full transaction on the round-robin instance, driven from an IDLE cycle.
    task automatic txn(input logic iv, input logic dv, input logic wen, input logic [31:0] ia,
                       input logic [31:0] da, input logic [127:0] dwd, input logic src,
                       input int hold, input logic [127:0] rd, input logic drop_both);
        logic [127:0] iwd;
        logic [162:0] want;
        iwd = {4{ia}};
        InstrReq = mk(iv, wen, ia, iwd);
        DataReq  = mk(dv, wen, da, dwd);
        sb.push_back(src ? {1'b1, wen, 1'b1, da, dwd} : {1'b1, wen, 1'b0, ia, iwd});
        tick;
        chk("grant_valid", {162'd0, L2Req[162]}, 163'd1);
        want = sb.pop_front();
        chk("grant_req", L2Req, want);
        chk("busy_set", {162'd0, Busy}, 163'd1);
        repeat (hold) tick;
        chk("req_held", L2Req, want);
        L2Resp = {1'b1, src, rd};
        #1;
        chk("instr_resp", {34'd0, InstrResp}, {34'd0, !src, rd});
        chk("data_resp", {34'd0, DataResp}, {34'd0, src, rd});
        tick;
        L2Resp = '0;
        if (drop_both || src) DataReq[161] = 1'b0;
        if (drop_both || !src) InstrReq[161] = 1'b0;
        chk("done_valid", {162'd0, L2Req[162]}, 163'd0);
        chk("done_busy", {162'd0, Busy}, 163'd0);
    endtask

    initial begin
        logic [162:0] want;
        vecs[0] = '{iv:1, dv:0, wen:0, ia:32'h0000_1000, da:32'h0000_2000, src:0};
        vecs[1] = '{iv:0, dv:1, wen:0, ia:32'h0000_1040, da:32'h0000_2040, src:1};
        vecs[2] = '{iv:1, dv:1, wen:0, ia:32'h0000_1080, da:32'h0000_2080, src:0};
        vecs[3] = '{iv:1, dv:1, wen:1, ia:32'h0000_10C0, da:32'h0000_20C0, src:1};
        vecs[4] = '{iv:1, dv:0, wen:1, ia:32'h0000_1100, da:32'h0000_2100, src:0};
        vecs[5] = '{iv:1, dv:1, wen:0, ia:32'h0000_1140, da:32'h0000_2140, src:1};

        do_reset;
        chk("rst_req", L2Req, 163'd0);
        chk("rst_busy", {162'd0, Busy}, 163'd0);
        chk("rst_err", {162'd0, DstErr}, 163'd0);

        // Ready while idle is ignored.
        L2Resp = {1'b1, 1'b0, RD_A};
        #1;
        chk("idle_iresp", {162'd0, InstrResp[128]}, 163'd0);
        chk("idle_dresp", {162'd0, DataResp[128]}, 163'd0);
        tick;
        L2Resp = '0;
        chk("idle_busy", {162'd0, Busy}, 163'd0);
        chk("idle_err", {162'd0, DstErr}, 163'd0);

        txn(1, 0, 0, 32'h0000_0BC0, 32'h0, 128'd0, 0, 2, RD_A, 1);

        // Tie right after reset goes to data, held instr follows, next tie goes to data again.
        do_reset;
        txn(1, 1, 0, 32'h0000_0100, 32'h0000_0200, 128'hA5, 1, 0, 128'h11, 0);
        txn(1, 0, 0, 32'h0000_0100, 32'h0000_0200, 128'hA5, 0, 0, 128'h22, 0);
        txn(1, 1, 0, 32'h0000_0300, 32'h0000_0400, 128'h5A, 1, 1, 128'h33, 1);

        txn(0, 1, 1, 32'h0, 32'h0001_0040, WB_D, 1, 10, 128'h44, 1);

        // Misrouted response while BUSY_I.
        InstrReq = mk(1, 0, 32'h0000_0500, {4{32'h0000_0500}});
        sb.push_back({1'b1, 1'b0, 1'b0, 32'h0000_0500, {4{32'h0000_0500}}});
        tick;
        want = sb.pop_front();
        chk("err_grant", L2Req, want);
        L2Resp = {1'b1, 1'b1, RD_A};
        #1;
        chk("err_iresp", {162'd0, InstrResp[128]}, 163'd0);
        chk("err_dresp", {162'd0, DataResp[128]}, 163'd0);
        tick;
        L2Resp = '0;
        chk("err_flag", {162'd0, DstErr}, 163'd1);
        chk("err_busy", {162'd0, Busy}, 163'd1);
        chk("err_held", L2Req, want);
        L2Resp = {1'b1, 1'b0, RD_A};
        #1;
        chk("err_fix_iresp", {34'd0, InstrResp}, {34'd0, 1'b1, RD_A});
        tick;
        L2Resp = '0;
        InstrReq = '0;
        chk("err_fix_busy", {162'd0, Busy}, 163'd0);
        chk("err_sticky", {162'd0, DstErr}, 163'd1);

        // Reset in the middle of a data transaction.
        do_reset;
        DataReq = mk(1, 0, 32'h0000_0600, 128'h66);
        tick;
        chk("mid_busy", {162'd0, Busy}, 163'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        DataReq = '0;
        chk("mid_req", L2Req, 163'd0);
        chk("mid_idle", {162'd0, Busy}, 163'd0);
        L2Resp = {1'b1, 1'b1, RD_A};
        #1;
        chk("mid_late_dresp", {162'd0, DataResp[128]}, 163'd0);
        tick;
        L2Resp = '0;
        chk("mid_late_busy", {162'd0, Busy}, 163'd0);
        chk("mid_late_err", {162'd0, DstErr}, 163'd0);
        txn(1, 1, 0, 32'h0000_0700, 32'h0000_0800, 128'h77, 1, 0, 128'h88, 1);

        do_reset;
        for (int i = 0; i < 6; i++)
            txn(vecs[i].iv, vecs[i].dv, vecs[i].wen, vecs[i].ia, vecs[i].da,
                {4{~vecs[i].da}}, vecs[i].src, i % 3, {4{vecs[i].ia}}, 1);

        // Fixed priority: data keeps winning while both stay valid.
        do_reset;
        f_instr_req = mk(1, 0, 32'h0000_0900, 128'h99);
        for (int k = 0; k < 3; k++) begin
            f_data_req = mk(1, 0, 32'h0000_0A00 + 32'(k), 128'(k + 5));
            sb.push_back({1'b1, 1'b0, 1'b1, 32'h0000_0A00 + 32'(k), 128'(k + 5)});
            tick;
            want = sb.pop_front();
            chk("fp_grant", f_l2_req, want);
            f_l2_resp = {1'b1, 1'b1, 128'(k)};
            #1;
            chk("fp_dresp", {162'd0, f_data_resp[128]}, 163'd1);
            chk("fp_iresp", {162'd0, f_instr_resp[128]}, 163'd0);
            tick;
            f_l2_resp = '0;
            chk("fp_done", {162'd0, f_busy}, 163'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
